// File: rtl/switch_pkg.sv
// Shared switch-bus types and default debounce timing constants.
package switch_pkg;
  localparam int SW_WIDTH         = 24;
  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_STABLE_TICKS = 4;

  typedef logic [SW_WIDTH-1:0] sw_vec_t;

  // Counter width for a 0..n-1 range, never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// One switch line: 2-FF synchronizer, consecutive-disagreement counter, stable level.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic stable,
  output logic update
);
  localparam int            CW      = cnt_width(STABLE_TICKS);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic          sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  // Any agreeing tick restarts the count; the STABLE_TICKS-th disagreeing tick accepts.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    if (tick) begin
      if (sync2_q == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        cnt_d    = '0;
        update   = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign stable = stable_q;
endmodule

// File: rtl/switch_debounce.sv
// Debounced switch bus with shared sample tick and change strobe.
// Optional per-bit rise/fall pulses when SWITCH_DEBOUNCE_EDGE_EN is defined.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int WIDTH        = SW_WIDTH,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic             changed
`ifdef SWITCH_DEBOUNCE_EDGE_EN
  ,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
`endif
);
  localparam int            TW       = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

  logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [WIDTH-1:0] update;
  logic             changed_q;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt_q <= '0;
      changed_q  <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      changed_q  <= |update;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.STABLE_TICKS(STABLE_TICKS)) u_bit (
      .clock  (clock),
      .reset  (reset),
      .tick   (tick),
      .raw    (switches_raw[i]),
      .stable (switches[i]),
      .update (update[i])
    );
  end

  assign changed = changed_q;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
  // update[i] implies the new level is the inverse of the current one.
  logic [WIDTH-1:0] rise_q, fall_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= update & ~switches;
      fall_q <= update & switches;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif
endmodule

// File: doc/switch_debounce.md
# switch_debounce

Front-end conditioning stage for the board's 24 slide switches, placed between the FPGA pins and the switch I/O register that the CPU reads through `ioRead`/`SwitchCtrl`. It synchronises each raw switch line into the `clock` domain and filters out contact bounce with a shared sample tick and per-bit consecutive-agreement counters. It then presents a clean, registered 24-bit `switches` bus to the downstream I/O register, along with a one-cycle change strobe.

## Interface
Parameters:
- `WIDTH`, 24: number of switch lines.
- `TICK_DIV`, 100000: clocks per sample tick; 1 ms at 100 MHz; legal range ≥1.
- `STABLE_TICKS`, 4: consecutive disagreeing ticks required to accept a new level; legal range ≥1.

Ports:
- `clock` in 1: system clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `switches_raw` in WIDTH: unsynchronised pin levels.
- `switches` out WIDTH: debounced levels, registered; feeds the switch I/O register.
- `changed` out 1: one-cycle pulse on any update of `switches`.
- `rise` out WIDTH: per-bit 0→1 pulse; present only with the macro defined.
- `fall` out WIDTH: per-bit 1→0 pulse; present only with the macro defined.

## Operation
- **Synchronizer:** two flip-flops per bit, producing `sync`.
- **Tick generator:** `tick_cnt` counts 0..TICK_DIV-1 and wraps. `tick` is high in the cycle where `tick_cnt == TICK_DIV-1`. With TICK_DIV=1, `tick` is high every cycle.
- **Per-bit filter,** evaluated only when `tick` is high (between ticks the counter holds):
  - If `sync[i] == switches[i]`: clear `cnt[i]` to 0.
  - Otherwise, if `cnt[i] == STABLE_TICKS-1`: `switches[i]` takes `sync[i]` and `cnt[i]` clears.
  - Otherwise: `cnt[i]` increments.
- **Acceptance rule:** a bit toggles only after STABLE_TICKS consecutive ticks disagree. A single agreeing tick restarts the count.
- **`changed`:** high for exactly the one cycle in which the updated `switches` value is first visible, i.e. registered together with `switches`.
- **Simultaneous qualification:** when several bits qualify on the same tick, they all update together and produce a single `changed` pulse.
- **Counter width:** `cnt` is clog2(STABLE_TICKS) wide, minimum 1 bit. `cnt` never exceeds STABLE_TICKS-1.

## Timing
- **Reset values:** `switches`=0, `changed`=0, `rise`/`fall`=0. Synchronizer flops, `tick_cnt` and all `cnt` are also 0.
- **Latency** from a clean raw step to the `switches` update:
  - Minimum: 2 + (STABLE_TICKS-1)·TICK_DIV + 1 cycles.
  - Maximum: 2 + STABLE_TICKS·TICK_DIV + 1 cycles.
- **Glitch rejection:** a raw pulse spanning fewer than STABLE_TICKS consecutive ticks never reaches `switches`.
- **Reset mid-count:** all progress is discarded. After reset release, every bit counts from 0 again.
  - Switches that are physically ON reappear after full latency.
  - Those switches raise `changed`, and `rise` when enabled.
- **Wrap:** `tick_cnt` wraps with no lost or doubled tick.

## Configuration
- Macro `SWITCH_DEBOUNCE_EDGE_EN`.
- **Defined:** `rise`/`fall` ports exist.
  - `rise[i]` = new `switches[i]` & ~old; `fall[i]` = ~new & old.
  - Each pulse lasts one cycle and is aligned with `changed`.
- **Undefined:** the ports and their logic are absent. `switches` and `changed` behave identically in both builds.

## Structure
- **Package `switch_pkg`:**
  - `SW_WIDTH`=24.
  - Default `TICK_DIV` and `STABLE_TICKS` constants.
  - `sw_vec_t` typedef (logic [SW_WIDTH-1:0]), shared with the switch I/O register.
- **Sub-module `debounce_bit`:** holds one bit's 2-FF synchronizer, counter and stable register, with inputs `tick`/`raw` and outputs `stable`/`update`. It is instantiated WIDTH times via generate.
- **Top level:** holds the tick generator, the `changed` OR-reduction and the optional edge logic.

## Test plan
Bench parameters: TICK_DIV=4, STABLE_TICKS=3 unless stated.
1. **Reset:** hold `reset`=0 with `switches_raw`=24'hFFFFFF → `switches`=0, `changed`=0 throughout.
2. **Clean step:** `switches_raw[0]` 0→1 and held → `switches[0]`=1 within 11..15 cycles; `changed` high for exactly 1 cycle; other bits stay 0.
3. **Glitch:** `switches_raw[5]` high for 6 cycles then low → `switches` stays 24'h000000; `changed` never asserts.
4. **Simultaneous:** `switches_raw`=24'h00A5F0 in one cycle → `switches` goes 0→24'h00A5F0 in a single cycle; exactly one `changed` pulse.
5. **Reset mid-count:** raise `switches_raw[3]` and assert `reset` after 2 ticks; release while raw stays high → `switches[3]`=0 during reset; it rises only after the full latency measured from release.
6. **Edges** (`SWITCH_DEBOUNCE_EDGE_EN` defined): `switches[7]` settled at 1, then `switches_raw[7]`→0 → `fall[7]` pulses once, aligned with `changed`; `rise` stays 24'h000000.
